// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the pipeline registers of the RV32I core.
// Holds the datapath widths, opcode constants, the control-signal encodings
// produced by the decoder and the packed control bundle carried down the pipe.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Datapath and register-file geometry
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Branch condition select; 000 means "not a branch" so a bubble never branches
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BLTU = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;

    // Jump type; 00 means "no jump"
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    // Write-back result source
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Control bundle carried from decode into execute; all-zero is a NOP
    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic [1:0] jump;
        logic [2:0] branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
// Generic pipeline register slice shared by the IF/ID, ID/EX and EX/MEM stages.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (clears to zero)
//   en_i  - load enable; low holds the current contents (stall)
//   clr_i - synchronous clear; wins over en_i
//   d_i   - next-stage data in  [WIDTH-1:0]
//   q_o   - registered data out [WIDTH-1:0]
// ---------------------------------------------------------------------------
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Clear has priority over enable so a flush during a stall still yields a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_ex_register.sv
// ---------------------------------------------------------------------------
// id_ex_register
// Decode-to-execute pipeline register. Carries the decoder control bundle,
// operand data and register indices into the execute stage, with stall
// (enE low) and flush (flushE high, inserts an all-zero bubble).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   enE, flushE         - load enable / synchronous bubble insert
//   *D inputs           - decode-stage control, data and register indices
//   *E outputs          - the same fields, one cycle later
//   validE              - E stage holds a real instruction (not a bubble)
//   flushCnt            - 16-bit bubble counter, only when the macro
//                         ID_EX_FLUSH_CNT_EN is defined
// ---------------------------------------------------------------------------
module id_ex_register
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enE,
    input  logic                  flushE,
    input  logic                  regWriteD,
    input  logic                  memWriteD,
    input  logic                  ALUSrcD,
    input  logic [1:0]            resultSrcD,
    input  logic [1:0]            jumpD,
    input  logic [2:0]            branchD,
    input  logic [2:0]            ALUControlD,
    input  logic [XLEN-1:0]       RD1D,
    input  logic [XLEN-1:0]       RD2D,
    input  logic [XLEN-1:0]       PCD,
    input  logic [XLEN-1:0]       immExtD,
    input  logic [XLEN-1:0]       PCPlus4D,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    output logic                  regWriteE,
    output logic                  memWriteE,
    output logic                  ALUSrcE,
    output logic [1:0]            resultSrcE,
    output logic [1:0]            jumpE,
    output logic [2:0]            branchE,
    output logic [2:0]            ALUControlE,
    output logic [XLEN-1:0]       RD1E,
    output logic [XLEN-1:0]       RD2E,
    output logic [XLEN-1:0]       PCE,
    output logic [XLEN-1:0]       immExtE,
    output logic [XLEN-1:0]       PCPlus4E,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic                  validE
`ifdef ID_EX_FLUSH_CNT_EN
    ,
    output logic [15:0]           flushCnt
`endif
);

    localparam int CTRL_W = $bits(ctrl_t) + 1;
    localparam int DATA_W = 5 * XLEN + 3 * REG_ADDR_W;

    ctrl_t             ctrlD;
    ctrl_t             ctrlE;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    assign ctrlD.regWrite   = regWriteD;
    assign ctrlD.resultSrc  = resultSrcD;
    assign ctrlD.memWrite   = memWriteD;
    assign ctrlD.jump       = jumpD;
    assign ctrlD.branch     = branchD;
    assign ctrlD.ALUControl = ALUControlD;
    assign ctrlD.ALUSrc     = ALUSrcD;

    // The valid flag rides in the control slice with a constant 1 on its input,
    // so a load sets it and a flush or reset clears it together with the controls.
    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (enE),
        .clr_i (flushE),
        .d_i   ({ctrlD, 1'b1}),
        .q_o   (ctrl_q)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (enE),
        .clr_i (flushE),
        .d_i   ({RD1D, RD2D, PCD, immExtD, PCPlus4D, Rs1D, Rs2D, RdD}),
        .q_o   (data_q)
    );

    assign {ctrlE, validE} = ctrl_q;
    assign {RD1E, RD2E, PCE, immExtE, PCPlus4E, Rs1E, Rs2E, RdE} = data_q;

    assign regWriteE   = ctrlE.regWrite;
    assign resultSrcE  = ctrlE.resultSrc;
    assign memWriteE   = ctrlE.memWrite;
    assign jumpE       = ctrlE.jump;
    assign branchE     = ctrlE.branch;
    assign ALUControlE = ctrlE.ALUControl;
    assign ALUSrcE     = ctrlE.ALUSrc;

`ifdef ID_EX_FLUSH_CNT_EN
    logic [15:0] flushCnt_q;
    logic [15:0] flushCnt_d;

    // Counts every flush edge, stalled or not; natural 16-bit wrap
    always_comb begin
        flushCnt_d = flushCnt_q;
        if (flushE) begin
            flushCnt_d = flushCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushCnt_q <= '0;
        end else begin
            flushCnt_q <= flushCnt_d;
        end
    end

    assign flushCnt = flushCnt_q;
`endif

endmodule
